// File: rtl/t_flip_flop_pkg.sv
// Shared constants and types for the toggle flip-flop bank.
package t_flip_flop_pkg;

    localparam int T_FF_DEFAULT_WIDTH = 1;

    typedef logic [T_FF_DEFAULT_WIDTH-1:0] t_ff_vec_t;

endpackage

// File: rtl/t_flip_flop_bit.sv
// One toggle storage bit with synchronous active-high reset to a per-bit value.
module t_flip_flop_bit #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);

    // Reset wins over a pending toggle; otherwise t selects invert or hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VAL;
        end else begin
            q <= q ^ t;
        end
    end

endmodule

// File: rtl/t_flip_flop.sv
// Bank of independent toggle flip-flops with complementary outputs.
// Define T_FLIP_FLOP_ASSERT_EN to elaborate simulation-only protocol checks.
module t_flip_flop
    import t_flip_flop_pkg::*;
#(
    parameter int               WIDTH     = T_FF_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        t_flip_flop_bit #(
            .RESET_VAL(RESET_VAL[i])
        ) u_bit (
            .clk(clk),
            .rst(rst),
            .t  (t[i]),
            .q  (q[i])
        );
    end

    // Derived from the register itself so q and qb can never disagree.
    assign qb = ~q;

`ifdef T_FLIP_FLOP_ASSERT_EN
    logic resetSeen;

    // Checks stay quiet until the first reset edge has given q a known value.
    always_ff @(posedge clk) begin
        if (rst) begin
            resetSeen <= 1'b1;
        end
    end

    a_qb_complement : assert property (@(posedge clk)
        disable iff (resetSeen !== 1'b1) qb == ~q);

    a_reset_value : assert property (@(posedge clk)
        disable iff (resetSeen !== 1'b1) $past(rst) |-> q == RESET_VAL);

    a_toggle : assert property (@(posedge clk)
        disable iff (resetSeen !== 1'b1) !$past(rst) |-> q == ($past(q) ^ $past(t)));

    a_t_known : assert property (@(posedge clk)
        disable iff (resetSeen !== 1'b1) !rst |-> !$isunknown(t));
`endif

endmodule

// File: tb/tb_t_flip_flop.sv
// Scoreboard bench for t_flip_flop: a default 1-bit instance and a 4-bit instance
// with a non-zero reset value, checked against a toggle-parity reference model.
module tb_t_flip_flop;

    localparam logic [3:0] RV4 = 4'b1010;

    logic       clk = 1'b0;
    logic       rst;
    logic       t1;
    logic [3:0] t4;
    logic       q1, qb1;
    logic [3:0] q4, qb4;

    int checks = 0;
    int errors = 0;

    logic       exp1Q[$];
    logic [3:0] exp4Q[$];

    // Reference model: each bit is its reset value flipped once per toggle
    // request seen since the last reset edge.
    int togg1;
    int togg4[4];

    t_flip_flop dut1 (
        .clk(clk),
        .rst(rst),
        .t  (t1),
        .q  (q1),
        .qb (qb1)
    );

    t_flip_flop #(
        .WIDTH    (4),
        .RESET_VAL(RV4)
    ) dut4 (
        .clk(clk),
        .rst(rst),
        .t  (t4),
        .q  (q4),
        .qb (qb4)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [3:0] actual,
                               input logic [3:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive on the falling edge and record what the next rising edge must produce.
    task automatic applyStimulus(input logic r, input logic tv1, input logic [3:0] tv4);
        logic [3:0] e4;
        @(negedge clk);
        rst = r;
        t1  = tv1;
        t4  = tv4;
        if (r) begin
            togg1 = 0;
            for (int i = 0; i < 4; i++) togg4[i] = 0;
        end else begin
            togg1 += int'(tv1);
            for (int i = 0; i < 4; i++) togg4[i] += int'(tv4[i]);
        end
        for (int i = 0; i < 4; i++) e4[i] = RV4[i] ^ (togg4[i] % 2 == 1);
        exp1Q.push_back(togg1 % 2 == 1);
        exp4Q.push_back(e4);
    endtask

    // Monitor: every rising edge presents a new output pair for each instance.
    initial begin
        logic       e1;
        logic [3:0] e4;
        forever begin
            @(posedge clk);
            #1;
            if (exp1Q.size() > 0) begin
                e1 = exp1Q.pop_front();
                e4 = exp4Q.pop_front();
                checkOutput("q1",  {3'b000, q1},  {3'b000, e1});
                checkOutput("qb1", {3'b000, qb1}, {3'b000, ~e1});
                checkOutput("q4",  q4,  e4);
                checkOutput("qb4", qb4, ~e4);
            end
        end
    end

    initial begin
        logic [5:0] seq;
        rst = 1'b0;
        t1  = 1'b0;
        t4  = 4'b0000;
        togg1 = 0;
        for (int i = 0; i < 4; i++) togg4[i] = 0;

        $display("[TB] reset and hold");
        applyStimulus(1'b1, 1'b0, 4'b0000);
        applyStimulus(1'b0, 1'b0, 4'b0000);
        applyStimulus(1'b0, 1'b0, 4'b0000);

        $display("[TB] toggle sequence 0,1,1,0,1,0");
        seq = 6'b010110;
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, seq[i], 4'b0110);

        $display("[TB] continuous toggle");
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 4'b1111);

        $display("[TB] reset priority over toggle");
        applyStimulus(1'b1, 1'b0, 4'b0000);
        applyStimulus(1'b0, 1'b1, 4'b1111);
        applyStimulus(1'b1, 1'b1, 4'b1111);
        applyStimulus(1'b0, 1'b1, 4'b0110);

        $display("[TB] reset held several cycles");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 4'b1111);
        applyStimulus(1'b0, 1'b1, 4'b0101);

        $display("[TB] random traffic");
        for (int i = 0; i < 300; i++) begin
            applyStimulus($urandom_range(0, 11) == 0, 1'($urandom), 4'($urandom));
        end

        @(posedge clk);
        #2;
        checkOutput("drain", 4'(exp1Q.size()), 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
